// File: rtl/alu_sequencer.sv
// Command-driven controller for an 8-bit combinational ALU: takes one op per handshake,
// drives the ALU from registers, optionally chains the result back, returns it on a response port.
module alu_sequencer #(
  parameter int unsigned ALU_LAT = 1,
  parameter logic [3:0]  ILL_SEL = 4'b1111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_sel,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic       cmd_use_acc,
  input  logic [3:0] cmd_rpt,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_sel,
  input  logic [7:0] alu_z,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_z,
  output logic       rsp_err,
  output logic [7:0] acc,
  output logic       busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] WAIT_INIT = 4'(ALU_LAT - 1);

  logic [1:0] state_q, state_d;
  logic       cmd_ready_q, cmd_ready_d;
  logic [7:0] alu_a_q, alu_a_d;
  logic [7:0] alu_b_q, alu_b_d;
  logic [3:0] alu_sel_q, alu_sel_d;
  logic [3:0] rpt_left_q, rpt_left_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] rsp_z_q, rsp_z_d;
  logic       rsp_err_q, rsp_err_d;
  logic       rsp_valid_q, rsp_valid_d;

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rpt_left_d  = rpt_left_q;
    wait_cnt_d  = wait_cnt_q;
    acc_d       = acc_q;
    rsp_z_d     = rsp_z_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = rsp_valid_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          rpt_left_d = cmd_rpt;
          wait_cnt_d = WAIT_INIT;
          if (cmd_sel == ILL_SEL) begin
            // Rejected op leaves the ALU inputs and accumulator untouched.
            state_d   = RESP;
            rsp_err_d = 1'b1;
            rsp_z_d   = 8'h00;
          end else begin
            alu_a_d   = cmd_use_acc ? acc_q : cmd_a;
            alu_b_d   = cmd_b;
            alu_sel_d = cmd_sel;
            state_d   = EXEC;
          end
        end
      end
      EXEC: begin
        if (wait_cnt_q == 4'd0) begin
          acc_d   = alu_z;
          rsp_z_d = alu_z;
          if (rpt_left_q != 4'd0) begin
            alu_a_d    = alu_z;
            rpt_left_d = rpt_left_q - 4'd1;
            wait_cnt_d = WAIT_INIT;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
          end
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      RESP: begin
        // An illegal-sel entry arrives with rsp_valid low; raise it one cycle later.
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      alu_a_q     <= 8'h00;
      alu_b_q     <= 8'h00;
      alu_sel_q   <= 4'h0;
      rpt_left_q  <= 4'h0;
      wait_cnt_q  <= 4'h0;
      acc_q       <= 8'h00;
      rsp_z_q     <= 8'h00;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rpt_left_q  <= rpt_left_d;
      wait_cnt_q  <= wait_cnt_d;
      acc_q       <= acc_d;
      rsp_z_q     <= rsp_z_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_err   = rsp_err_q;
  assign acc       = acc_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed cases plus random commands against an iterative result model.
module tb_alu_sequencer;

  localparam int unsigned LAT = 1;
  localparam logic [3:0]  ILL = 4'b1111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_sel = 4'h0;
  logic [7:0] cmd_a = 8'h00;
  logic [7:0] cmd_b = 8'h00;
  logic       cmd_use_acc = 1'b0;
  logic [3:0] cmd_rpt = 4'h0;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_z;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_z;
  logic       rsp_err;
  logic [7:0] acc;
  logic       busy;

  int checks = 0;
  int failures = 0;

  // Reference-model state
  logic [7:0] m_acc = 8'h00;
  logic [3:0] m_sel = 4'h0;
  logic [7:0] exp_z;
  logic       exp_err;
  int         exp_lat;

  always #5 clk = ~clk;

  alu_sequencer #(.ALU_LAT(LAT), .ILL_SEL(ILL)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel), .cmd_a(cmd_a),
    .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .cmd_rpt(cmd_rpt),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_z(rsp_z), .rsp_err(rsp_err),
    .acc(acc), .busy(busy)
  );

  function automatic logic [7:0] alu_f(logic [3:0] s, logic [7:0] a, logic [7:0] b);
    case (s)
      4'd0: return a + b;
      4'd1: return a << 1;
      4'd2: return a - b;
      4'd3: return a & b;
      4'd4: return a | b;
      4'd5: return a ^ b;
      default: return a;
    endcase
  endfunction

  assign alu_z = alu_f(alu_sel, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b,
                       input logic ua, input logic [3:0] r);
    cmd_sel = s; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_rpt = r; cmd_valid = 1'b1;
  endtask

  task automatic model(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b,
                       input logic ua, input logic [3:0] r);
    logic [7:0] x;
    x = ua ? m_acc : a;
    if (s == ILL) begin
      exp_err = 1'b1; exp_z = 8'h00; exp_lat = 1;
    end else begin
      for (int i = 0; i <= int'(r); i++) x = alu_f(s, x, b);
      exp_err = 1'b0; exp_z = x; exp_lat = (int'(r) + 1) * int'(LAT);
      m_acc = x; m_sel = s;
    end
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    check("accept_timeout", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int hold, input string tag);
    int lat;
    lat = 0;
    while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_z"}, {24'd0, rsp_z}, {24'd0, exp_z});
    check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    check({tag, "_acc"}, {24'd0, acc}, {24'd0, m_acc});
    check({tag, "_sel"}, {28'd0, alu_sel}, {28'd0, m_sel});
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
      check({tag, "_hold_z"}, {24'd0, rsp_z}, {24'd0, exp_z});
      check({tag, "_hold_ready"}, {31'd0, cmd_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check({tag, "_done_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_done_ready"}, {31'd0, cmd_ready}, 32'd1);
    check({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b,
                     input logic ua, input logic [3:0] r, input int hold, input string tag);
    rsp_ready = (hold == 0);
    drive(s, a, b, ua, r);
    wait_accept();
    model(s, a, b, ua, r);
    wait_rsp(hold, tag);
  endtask

  initial begin
    logic [3:0] rs;
    int seen;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_acc", {24'd0, acc}, 32'd0);
    check("rst_alu", {12'd0, alu_a, alu_b, alu_sel}, 32'd0);
    check("rst_rsp", {29'd0, rsp_valid, rsp_err, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", {31'd0, cmd_ready}, 32'd1);

    // Directed cases
    run(4'd0, 8'h01, 8'h01, 1'b0, 4'd0, 0, "add11");
    run(4'd0, 8'h55, 8'h03, 1'b1, 4'd2, 0, "acc_rpt2");
    run(ILL, 8'h12, 8'h34, 1'b0, 4'd0, 0, "illegal");

    // Held response, second command pending while busy
    rsp_ready = 1'b0;
    drive(4'd0, 8'h10, 8'h20, 1'b0, 4'd0);
    wait_accept();
    model(4'd0, 8'h10, 8'h20, 1'b0, 4'd0);
    drive(4'd2, 8'h40, 8'h01, 1'b0, 4'd1);
    wait_rsp(5, "held");
    check("pending_valid", {31'd0, cmd_valid}, 32'd1);
    wait_accept();
    model(4'd2, 8'h40, 8'h01, 1'b0, 4'd1);
    wait_rsp(0, "pending");

    run(4'd0, 8'hFF, 8'h01, 1'b0, 4'd0, 0, "wrap");
    run(4'd1, 8'h81, 8'h00, 1'b0, 4'd1, 0, "shl_rpt1");
    run(4'd0, 8'h00, 8'h01, 1'b0, 4'hF, 0, "rpt15");

    // Random commands
    for (int i = 0; i < 40; i++) begin
      rs = 4'($urandom_range(0, 6));
      if (rs == 4'd6) rs = ILL;
      run(rs, 8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom_range(0, 3)),
          int'($urandom_range(0, 2)), "rand");
    end

    // Reset mid-operation
    rsp_ready = 1'b1;
    drive(4'd0, 8'h01, 8'h02, 1'b0, 4'd5);
    wait_accept();
    @(negedge clk);
    check("abort_busy_pre", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_acc", {24'd0, acc}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ready", {31'd0, cmd_ready}, 32'd0);
    check("abort_valid", {31'd0, rsp_valid}, 32'd0);
    m_acc = 8'h00; m_sel = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_rel_ready", {31'd0, cmd_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("abort_no_rsp", seen, 0);
    run(4'd0, 8'h07, 8'h08, 1'b1, 4'd0, 1, "post_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
